// File: rtl/led_show_pkg.sv
// Shared codes and constants for the LED show controller: FSM encoding,
// mode codes, per-mode initial patterns and small mode helpers.
package led_show_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int NUM_MODES = 5;

  localparam logic [2:0] MODE_ROT_L  = 3'd0;
  localparam logic [2:0] MODE_ROT_R  = 3'd1;
  localparam logic [2:0] MODE_BOUNCE = 3'd2;
  localparam logic [2:0] MODE_FILL   = 3'd3;
  localparam logic [2:0] MODE_BLINK  = 3'd4;
  localparam logic [2:0] LAST_MODE   = 3'(NUM_MODES - 1);

  localparam logic [7:0] INIT_ROT_L  = 8'h01;
  localparam logic [7:0] INIT_ROT_R  = 8'h80;
  localparam logic [7:0] INIT_BOUNCE = 8'h01;
  localparam logic [7:0] INIT_FILL   = 8'h00;
  localparam logic [7:0] INIT_BLINK  = 8'h00;

  function automatic logic [7:0] init_pattern(input logic [2:0] m);
    case (m)
      MODE_ROT_L:  return INIT_ROT_L;
      MODE_ROT_R:  return INIT_ROT_R;
      MODE_BOUNCE: return INIT_BOUNCE;
      MODE_FILL:   return INIT_FILL;
      MODE_BLINK:  return INIT_BLINK;
      default:     return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] mode_after(input logic [2:0] m);
    return (m >= LAST_MODE) ? 3'd0 : m + 3'd1;
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Clock divider for the pattern step: counts 0..DIVIDER-1 while enabled and
// flags the wrap cycle combinationally so the step lands on the same edge.
module led_step_timer #(
  parameter int DIVIDER = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // clr beats en so a reload never also counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/led_show_ctrl.sv
// LED show controller: IDLE/RUN/PAUSE sequencer stepping one of five LED
// patterns, with host and button mode requests and optional auto-advance.
module led_show_ctrl
  import led_show_pkg::*;
#(
  parameter int DIVIDER        = 4,
  parameter int STEPS_PER_MODE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       auto_adv,
  input  logic       host_valid,
  input  logic [2:0] host_mode,
  output logic       host_ready,
  input  logic       btn_next,
  output logic [7:0] led,
  output logic [2:0] mode,
  output logic       busy,
  output logic       step_tick,
  output logic       req_err
);

  localparam int SW = (STEPS_PER_MODE > 1) ? $clog2(STEPS_PER_MODE) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS_PER_MODE - 1);

  state_t        state, state_nxt;
  logic [SW-1:0] step_cnt;
  logic          dir;
  logic          host_acc, host_legal, btn_acc, req_legal;
  logic [2:0]    req_mode, mode_nxt;
  logic          tmr_en, tmr_clr, wrap, adv;
  logic [7:0]    step_led;
  logic          step_dir;

  // Request arbitration: host beats button; stop drops the button only.
  assign host_acc   = host_valid && host_ready;
  assign host_legal = (host_mode <= LAST_MODE);
  assign btn_acc    = btn_next && !host_acc && (state != ST_PAUSE) && !stop;
  assign req_legal  = (host_acc && host_legal) || btn_acc;
  assign req_mode   = host_acc ? host_mode : mode_after(mode);
  assign mode_nxt   = req_legal ? req_mode : mode;

  // Any accepted request (even an illegal one) holds the divider for that cycle.
  assign tmr_en  = (state == ST_RUN) && !stop && !pause && !host_acc && !btn_acc;
  assign tmr_clr = stop || req_legal;

  led_step_timer #(.DIVIDER(DIVIDER)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tmr_en),
    .clr   (tmr_clr),
    .tick  (step_tick)
  );

  assign wrap = (step_cnt == LAST_STEP);
  assign adv  = step_tick && wrap && auto_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!stop && !pause && start) state_nxt = ST_RUN;
      ST_RUN:   if (stop) state_nxt = ST_IDLE;
                else if (pause) state_nxt = ST_PAUSE;
      ST_PAUSE: if (stop) state_nxt = ST_IDLE;
                else if (!pause) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    host_ready = (state != ST_PAUSE);
  end

  // Next pattern for the current mode; dir remembers BOUNCE travel (1 = right).
  always_comb begin
    step_led = led;
    step_dir = dir;
    case (mode)
      MODE_ROT_L:  step_led = {led[6:0], led[7]};
      MODE_ROT_R:  step_led = {led[0], led[7:1]};
      MODE_BOUNCE: begin
        if (led[7] || (dir && !led[0])) begin
          step_led = {1'b0, led[7:1]};
          step_dir = 1'b1;
        end else begin
          step_led = {led[6:0], 1'b0};
          step_dir = 1'b0;
        end
      end
      MODE_FILL:   step_led = (led == 8'hFF) ? 8'h00 : {led[6:0], 1'b1};
      MODE_BLINK:  step_led = ~led;
      default:     step_led = led;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= MODE_ROT_L;
      led      <= 8'h00;
      dir      <= 1'b0;
      step_cnt <= '0;
      req_err  <= 1'b0;
    end else begin
      req_err <= host_acc && !host_legal;
      mode    <= adv ? mode_after(mode) : mode_nxt;
      if (stop) begin
        led      <= 8'h00;
        step_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: if (start && !pause) begin
            led <= init_pattern(mode_nxt);
            dir <= 1'b0;
          end
          ST_RUN: begin
            if (req_legal) begin
              led      <= init_pattern(req_mode);
              dir      <= 1'b0;
              step_cnt <= '0;
            end else if (step_tick) begin
              step_cnt <= wrap ? '0 : step_cnt + SW'(1);
              if (adv) begin
                led <= init_pattern(mode_after(mode));
                dir <= 1'b0;
              end else begin
                led <= step_led;
                dir <= step_dir;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_show_ctrl.sv
// Scoreboard bench for led_show_ctrl: a position-based reference model pushes
// the expected per-cycle outputs; a separate monitor pops and compares them.
module tb_led_show_ctrl;

  localparam int DIV = 4;
  localparam int SPM = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, auto_adv = 1'b0;
  logic       host_valid = 1'b0, btn_next = 1'b0;
  logic [2:0] host_mode = 3'd0;
  logic       host_ready, busy, step_tick, req_err;
  logic [7:0] led;
  logic [2:0] mode;

  led_show_ctrl #(.DIVIDER(DIV), .STEPS_PER_MODE(SPM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .auto_adv   (auto_adv),
    .host_valid (host_valid),
    .host_mode  (host_mode),
    .host_ready (host_ready),
    .btn_next   (btn_next),
    .led        (led),
    .mode       (mode),
    .busy       (busy),
    .step_tick  (step_tick),
    .req_err    (req_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic [2:0] mode;
    logic       busy;
    logic       tick;
    logic       hr;
    logic       err;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0, fails = 0;
  bit   adv_lvl = 1'b0;

  // Model state: ms 0=idle 1=run 2=pause; pattern held as a position in its cycle.
  int ms = 0, mmode = 0, pos = 0, dcnt = 0, scnt = 0;
  bit merr = 1'b0;

  function automatic int period(input int m);
    case (m)
      0, 1:    return 8;
      2:       return 14;
      3:       return 9;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] led_of(input int m, input int p);
    int b;
    case (m)
      0: return 8'(1 << p);
      1: return 8'(128 >> p);
      2: begin b = (p <= 7) ? p : 14 - p; return 8'(1 << b); end
      3: return 8'((1 << p) - 1);
      default: return (p != 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic model_cycle();
    obs_t e;
    bit hr, hacc, hleg, bacc, req, tick;
    int rmode;
    hr    = (ms != 2);
    hacc  = host_valid && hr;
    hleg  = int'(host_mode) < 5;
    bacc  = btn_next && !hacc && (ms != 2) && !stop;
    req   = (hacc && hleg) || bacc;
    rmode = hacc ? int'(host_mode) : (mmode + 1) % 5;
    tick  = (ms == 1) && !stop && !pause && !hacc && !bacc && (dcnt == DIV - 1);
    e.led  = (ms == 0) ? 8'h00 : led_of(mmode, pos);
    e.mode = 3'(mmode);
    e.busy = (ms != 0);
    e.tick = tick;
    e.hr   = hr;
    e.err  = merr;
    exp_q.push_back(e);
    merr = hacc && !hleg;
    if (req) mmode = rmode;
    case (ms)
      0: if (!stop && !pause && start) begin ms = 1; pos = 0; end
      1: begin
        if (stop) begin dcnt = 0; scnt = 0; end
        else if (req) begin pos = 0; dcnt = 0; scnt = 0; end
        else if (!pause && !hacc) begin
          if (dcnt == DIV - 1) begin
            dcnt = 0;
            if (scnt == SPM - 1) begin
              scnt = 0;
              if (auto_adv) begin mmode = (mmode + 1) % 5; pos = 0; end
              else pos = (pos + 1) % period(mmode);
            end else begin
              scnt++;
              pos = (pos + 1) % period(mmode);
            end
          end else dcnt++;
        end
        ms = stop ? 0 : (pause ? 2 : 1);
      end
      default: begin
        if (stop) begin ms = 0; dcnt = 0; scnt = 0; end
        else if (!pause) ms = 1;
      end
    endcase
  endtask

  task automatic cyc(input bit st, input bit sp, input bit pa,
                     input bit hv, input int hm, input bit bn);
    @(negedge clk);
    rst_n = 1'b1; start = st; stop = sp; pause = pa;
    host_valid = hv; host_mode = 3'(hm); btn_next = bn; auto_adv = adv_lvl;
    model_cycle();
  endtask

  // Reset is asserted away from any clock edge; outputs must clear at once.
  task automatic rst_cyc();
    obs_t e;
    @(negedge clk);
    rst_n = 1'b0; start = 0; stop = 0; pause = 0;
    host_valid = 0; host_mode = 3'd0; btn_next = 0; auto_adv = adv_lvl;
    ms = 0; mmode = 0; pos = 0; dcnt = 0; scnt = 0; merr = 1'b0;
    e = '{led: 8'h00, mode: 3'd0, busy: 1'b0, tick: 1'b0, hr: 1'b1, err: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {led, mode, busy, step_tick, host_ready, req_err};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs @%0t: got led=%h mode=%0d busy=%b tick=%b rdy=%b err=%b, want led=%h mode=%0d busy=%b tick=%b rdy=%b err=%b",
                   $time, a.led, a.mode, a.busy, a.tick, a.hr, a.err,
                   e.led, e.mode, e.busy, e.tick, e.hr, e.err);
        end
      end
    end
  end

  initial begin
    bit pa_lvl;
    repeat (3) rst_cyc();
    run(2);
    cyc(1, 0, 0, 0, 0, 0);          // start in ROT_L
    run(40);
    cyc(0, 0, 0, 1, 2, 0);          // BOUNCE
    run(60);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0, 0);
    run(12);
    cyc(0, 0, 0, 1, 6, 0);          // illegal code
    run(3);
    cyc(0, 0, 0, 1, 3, 1);          // host beats button
    run(8);
    adv_lvl = 1'b1;
    cyc(0, 0, 0, 1, 4, 0);
    run(72);
    adv_lvl = 1'b0;
    cyc(0, 0, 0, 1, 4, 0);
    run(72);
    cyc(0, 0, 0, 1, 3, 0);          // FILL, reset near 0x3F
    run(26);
    repeat (2) rst_cyc();
    run(2);
    cyc(1, 0, 0, 0, 0, 0);
    run(10);
    cyc(0, 1, 0, 1, 1, 0);          // stop with host request
    run(3);
    cyc(0, 0, 0, 0, 0, 1);          // button in idle
    cyc(1, 0, 0, 1, 2, 0);          // start with host request
    run(10);
    cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 1, 1, 1, 1);          // requests in pause are refused
    cyc(0, 1, 1, 0, 0, 0);
    run(3);

    pa_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(499) == 0) begin
        rst_cyc();
      end else begin
        if ($urandom_range(19) == 0) pa_lvl = ~pa_lvl;
        if ($urandom_range(199) == 0) adv_lvl = ~adv_lvl;
        cyc($urandom_range(9) == 0, $urandom_range(59) == 0, pa_lvl,
            $urandom_range(11) == 0, int'($urandom_range(7)),
            $urandom_range(14) == 0);
      end
    end
    run(3);
    @(negedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_show_ctrl.md
LED_SHOW_CTRL -- requirements
Module: led_show_ctrl

Interface
REQ-001 Parameter DIVIDER, default 4: clk cycles per pattern step; legal values are >=1.
REQ-002 Parameter STEPS_PER_MODE, default 16: step ticks per mode before auto-advance; legal values are >=1.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level, sampled each cycle; begins the show.
REQ-006 stop  input  1  level; returns to idle.
REQ-007 pause  input  1  level; freezes the show while high.
REQ-008 auto_adv  input  1  level; 1 enables mode auto-advance.
REQ-009 host_valid  input  1  mode-change request valid.
REQ-010 host_mode  input  3  requested mode code.
REQ-011 host_ready  output  1  request accepted when host_valid && host_ready.
REQ-012 btn_next  input  1  single-cycle pulse; request the next mode.
REQ-013 led  output  8  LED pattern.
REQ-014 mode  output  3  current mode code.
REQ-015 busy  output  1  high in RUN or PAUSE.
REQ-016 step_tick  output  1  one-cycle pulse on each pattern step.
REQ-017 req_err  output  1  one-cycle pulse when an illegal host_mode is accepted.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and PAUSE.
REQ-019 Command priority SHALL be stop > pause > start, evaluated every cycle.
REQ-020 IDLE: led=0x00, divider and step counters at 0; start -> RUN with led loaded with the initial pattern of the current mode.
REQ-021 RUN: pause -> PAUSE; stop -> IDLE. PAUSE: stop -> IDLE; pause low -> RUN. Counters and led SHALL be frozen in PAUSE.
REQ-022 In RUN, the divider SHALL count 0..DIVIDER-1; at DIVIDER-1 it wraps to 0, step_tick pulses in that same cycle, and led advances on that edge.
REQ-023 Mode codes: 0 ROT_L, init 0x01, rotate left; 1 ROT_R, init 0x80, rotate right; 2 BOUNCE, init 0x01, single bit moving left to 0x80 then right to 0x01 with no repeat at the ends; 3 FILL, init 0x00, {led[6:0],1} until 0xFF, then 0x00; 4 BLINK, init 0x00, led=~led. Codes 5-7 are illegal.
REQ-024 The step counter SHALL increment on each step_tick; at STEPS_PER_MODE-1 it wraps to 0 and, if auto_adv=1, mode advances (4 wraps to 0) with led reloaded to the new mode's initial pattern instead of stepping.
REQ-025 host_ready SHALL be 1 in IDLE and RUN and 0 in PAUSE.
REQ-026 An accepted legal host request SHALL set mode on the next edge; in RUN it reloads the initial pattern and clears both counters. In IDLE only mode changes.
REQ-027 An accepted illegal request SHALL pulse req_err for one cycle and leave mode, led and counters unchanged.
REQ-028 btn_next SHALL act as a request for (mode+1) mod 5 under the same rules, ignored in PAUSE.
REQ-029 Simultaneous host accept and btn_next: host wins and the button pulse is dropped. A request coincident with auto-advance or step_tick: the request wins and no step occurs.
REQ-030 stop SHALL take effect over any coincident request; mode still updates from an accepted host request in that cycle.

Reset
REQ-031 Asynchronous reset SHALL set state=IDLE, mode=0, led=0x00, busy=0, step_tick=0, req_err=0, and both counters to 0; host_ready is 1 after reset.
REQ-032 Reset asserted mid-RUN SHALL take effect immediately without waiting for a clock edge; after release the block waits in IDLE for start.

Structure
REQ-033 Package led_show_pkg SHALL hold the mode codes, the state encoding, the per-mode initial-pattern constants and NUM_MODES=5.
REQ-034 The divider SHALL be a sub-module led_step_timer (inputs: clk, rst_n, en, clr; output: tick); everything else is in led_show_ctrl.

Verification (DIVIDER=4, STEPS_PER_MODE=16)
REQ-035 Reset, start pulse, mode 0 -> led 0x01, then 0x02 after 4 cycles, step_tick every 4th cycle, 0x01 again after 8 steps.
REQ-036 host_mode=2 in RUN -> led 0x01 next cycle; sequence 0x02..0x80,0x40..0x01; no 0x80 repeat at the end.
REQ-037 auto_adv=1 in mode 4 -> after 16 ticks mode=0 and led=0x01; with auto_adv=0, mode stays 4.
REQ-038 pause mid-run for 10 cycles -> led, counters and mode frozen, host_ready=0; on release, timing resumes at the held count.
REQ-039 host_valid with host_mode=6 -> req_err one-cycle pulse, no other change; host_mode=3 and btn_next in the same cycle -> mode=3.
REQ-040 Reset asserted mid-FILL at 0x3F -> led=0x00, mode=0, IDLE immediately; start after release -> led 0x01.
